// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the multicycle CPU control path: FSM states, opcodes,
// ALU operation codes and datapath mux select encodings.
package cpu_ctrl_pkg;

    localparam int OP_W    = 4;
    localparam int ALUOP_W = 3;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_EXEC_I   = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_MEM_WR   = 4'd6,
        ST_WB_ALU   = 4'd7,
        ST_WB_MEM   = 4'd8,
        ST_BRANCH   = 4'd9,
        ST_JUMP     = 4'd10,
        ST_HALT     = 4'd11
    } state_e;

    localparam logic [OP_W-1:0] OP_ADDI = 4'b0111;
    localparam logic [OP_W-1:0] OP_LW   = 4'b1000;
    localparam logic [OP_W-1:0] OP_SW   = 4'b1001;
    localparam logic [OP_W-1:0] OP_BEQ  = 4'b1010;
    localparam logic [OP_W-1:0] OP_JMP  = 4'b1011;
    localparam logic [OP_W-1:0] OP_HALT = 4'b1111;

    localparam logic [ALUOP_W-1:0] ALUOP_MOV = 3'b000;
    localparam logic [ALUOP_W-1:0] ALUOP_NOT = 3'b001;
    localparam logic [ALUOP_W-1:0] ALUOP_ADD = 3'b010;
    localparam logic [ALUOP_W-1:0] ALUOP_SUB = 3'b011;
    localparam logic [ALUOP_W-1:0] ALUOP_OR  = 3'b100;
    localparam logic [ALUOP_W-1:0] ALUOP_AND = 3'b101;
    localparam logic [ALUOP_W-1:0] ALUOP_XOR = 3'b110;

    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_ONE = 2'b01;
    localparam logic [1:0] SRCB_IMM = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic [ALUOP_W-1:0] alu_op;
        logic               alu_src_a;
        logic [1:0]         alu_src_b;
        logic [1:0]         pc_src;
        logic               pc_write;
        logic               ir_write;
        logic               iord;
        logic               mem_read;
        logic               mem_write;
        logic               reg_write;
        logic               mem_to_reg;
        logic               reg_dst_imm;
        logic               halted;
        logic               illegal;
    } ctrl_t;

    function automatic logic is_rtype(input logic [OP_W-1:0] op);
        return (op[3] == 1'b0) && (op[2:0] != 3'b111);
    endfunction

    function automatic logic is_illegal_op(input logic [OP_W-1:0] op);
        return (op == 4'b1100) || (op == 4'b1101) || (op == 4'b1110);
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Maps the controller state and latched opcode to the 3-bit ALU operation code.
// States with no ALU use drive MOV so the code stays within the defined set.
module alu_op_decode
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW    = 4,
    parameter int ALUOPW = 3
) (
    input  state_e            state,
    input  logic [OPW-1:0]    op,
    output logic [ALUOPW-1:0] alu_op
);

    always_comb begin
        alu_op = ALUOP_MOV;
        unique case (state)
            ST_FETCH,
            ST_DECODE,
            ST_EXEC_I,
            ST_MEM_ADDR: alu_op = ALUOP_ADD;
            // 111 is undefined at the ALU; an R-type opcode never carries it
            ST_EXEC_R:   alu_op = (op[2:0] == 3'b111) ? ALUOP_MOV : op[2:0];
            ST_BRANCH:   alu_op = ALUOP_SUB;
            default:     alu_op = ALUOP_MOV;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multicycle CPU: sequences fetch/decode/execute/memory/
// writeback and drives every datapath enable and mux select.
module multicycle_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW    = 4,
    parameter int ALUOPW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPW-1:0]    opcode,
    input  logic              zero,
    input  logic              mem_ready,
    output logic [ALUOPW-1:0] alu_op,
    output logic              alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        pc_src,
    output logic              pc_write,
    output logic              ir_write,
    output logic              iord,
    output logic              mem_read,
    output logic              mem_write,
    output logic              reg_write,
    output logic              mem_to_reg,
    output logic              reg_dst_imm,
    output logic              halted,
    output logic              illegal
);

    state_e            state_q, state_d;
    logic [OPW-1:0]    op_q, op_d;
    logic              illegal_q, illegal_d;
    logic [ALUOPW-1:0] alu_op_dec;
    ctrl_t             ctl;
    ctrl_t             ctl_out;

    alu_op_decode #(
        .OPW    (OPW),
        .ALUOPW (ALUOPW)
    ) u_alu_op_decode (
        .state  (state_q),
        .op     (op_q),
        .alu_op (alu_op_dec)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    // Next state; the opcode is captured in DECODE and only op_q is used afterwards
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        unique case (state_q)
            ST_FETCH: begin
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                op_d = opcode;
                if (is_rtype(opcode)) begin
                    state_d = ST_EXEC_R;
                end else if (is_illegal_op(opcode)) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else begin
                    unique case (opcode)
                        OP_ADDI:      state_d = ST_EXEC_I;
                        OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                        OP_BEQ:       state_d = ST_BRANCH;
                        OP_JMP:       state_d = ST_JUMP;
                        default:      state_d = ST_HALT;
                    endcase
                end
            end
            ST_EXEC_R,
            ST_EXEC_I:   state_d = ST_WB_ALU;
            ST_MEM_ADDR: state_d = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (mem_ready) state_d = ST_WB_MEM;
            end
            ST_MEM_WR: begin
                if (mem_ready) state_d = ST_FETCH;
            end
            ST_WB_ALU,
            ST_WB_MEM,
            ST_BRANCH,
            ST_JUMP:     state_d = ST_FETCH;
            ST_HALT:     state_d = ST_HALT;
            default:     state_d = ST_FETCH;
        endcase
    end

    always_comb begin
        ctl        = '0;
        ctl.alu_op = alu_op_dec;
        unique case (state_q)
            ST_FETCH: begin
                ctl.mem_read  = 1'b1;
                ctl.alu_src_b = SRCB_ONE;
                ctl.pc_src    = PCSRC_ALU;
                ctl.ir_write  = mem_ready;
                ctl.pc_write  = mem_ready;
            end
            ST_DECODE: begin
                ctl.alu_src_b = SRCB_IMM;
            end
            ST_EXEC_R: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_REG;
            end
            ST_EXEC_I,
            ST_MEM_ADDR: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_IMM;
            end
            ST_MEM_RD: begin
                ctl.mem_read = 1'b1;
                ctl.iord     = 1'b1;
            end
            ST_MEM_WR: begin
                ctl.mem_write = 1'b1;
                ctl.iord      = 1'b1;
            end
            ST_WB_ALU: begin
                ctl.reg_write   = 1'b1;
                ctl.reg_dst_imm = (op_q == OP_ADDI);
            end
            ST_WB_MEM: begin
                ctl.reg_write   = 1'b1;
                ctl.mem_to_reg  = 1'b1;
                ctl.reg_dst_imm = 1'b1;
            end
            ST_BRANCH: begin
                ctl.alu_src_a = 1'b1;
                ctl.alu_src_b = SRCB_REG;
                ctl.pc_src    = PCSRC_ALUOUT;
                ctl.pc_write  = zero;
            end
            ST_JUMP: begin
                ctl.pc_src   = PCSRC_JUMP;
                ctl.pc_write = 1'b1;
            end
            ST_HALT: begin
                ctl.halted  = 1'b1;
                ctl.illegal = illegal_q;
            end
            default: ctl = '0;
        endcase
    end

    // Outputs are forced to zero while reset is held, so an abandoned memory
    // write drops immediately rather than turning into a FETCH read request.
    always_comb begin
        ctl_out = '0;
        if (rst_n) ctl_out = ctl;
    end

    assign alu_op      = ctl_out.alu_op;
    assign alu_src_a   = ctl_out.alu_src_a;
    assign alu_src_b   = ctl_out.alu_src_b;
    assign pc_src      = ctl_out.pc_src;
    assign pc_write    = ctl_out.pc_write;
    assign ir_write    = ctl_out.ir_write;
    assign iord        = ctl_out.iord;
    assign mem_read    = ctl_out.mem_read;
    assign mem_write   = ctl_out.mem_write;
    assign reg_write   = ctl_out.reg_write;
    assign mem_to_reg  = ctl_out.mem_to_reg;
    assign reg_dst_imm = ctl_out.reg_dst_imm;
    assign halted      = ctl_out.halted;
    assign illegal     = ctl_out.illegal;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Self-checking bench: a per-instruction cycle timeline model builds expected
// control words, a negedge compare process checks the DUT against it.
`timescale 1ns/1ps
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic       pc_write, ir_write, iord, mem_read, mem_write;
    logic       reg_write, mem_to_reg, reg_dst_imm, halted, illegal;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.OPW(4), .ALUOPW(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_src(pc_src),
        .pc_write(pc_write), .ir_write(ir_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .reg_dst_imm(reg_dst_imm), .halted(halted), .illegal(illegal)
    );

    typedef struct packed {
        logic [2:0] alu_op;
        logic       a;
        logic [1:0] b;
        logic [1:0] pcs;
        logic       pcw, irw, iord, mr, mw, rw, m2r, rdi, hlt, ill;
    } ctl_t;

    typedef struct packed {
        logic       mr;
        logic       z;
        logic [3:0] op;
        ctl_t       exp;
    } step_t;

    ctl_t  act;
    assign act = {alu_op, alu_src_a, alu_src_b, pc_src, pc_write, ir_write, iord,
                  mem_read, mem_write, reg_write, mem_to_reg, reg_dst_imm, halted, illegal};

    step_t q[$];
    string tq[$];
    step_t cur;
    string cur_tag = "";
    bit    cur_valid = 1'b0;
    int    errors = 0;
    int    checks = 0;

    always @(negedge clk) begin
        if (cur_valid) begin
            checks++;
            if (act !== cur.exp) begin
                errors++;
                $display("FAIL %s: got %b expected %b", cur_tag, act, cur.exp);
            end
            checks++;
            if ((mem_read && mem_write) || (reg_write && pc_write) || (alu_op == 3'b111)) begin
                errors++;
                $display("FAIL invariant in %s: got mr=%b mw=%b rw=%b pcw=%b alu_op=%b required exclusive and alu_op!=111",
                         cur_tag, mem_read, mem_write, reg_write, pc_write, alu_op);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic add_step(input bit mr, input bit z, input logic [3:0] op, input ctl_t e, input string tag);
        step_t s;
        s.mr  = mr;
        s.z   = z;
        s.op  = op;
        s.exp = e;
        q.push_back(s);
        tq.push_back(tag);
    endtask

    // Timeline of one instruction: fs fetch stalls, ms memory stalls, hold cycles in halt.
    // Opcode pins carry a scrambled value outside DECODE; mem_ready is low where it must not matter.
    task automatic build(input logic [3:0] op, input int fs, input int ms, input bit z,
                         input int hold, output int n);
        logic [3:0] junk;
        ctl_t       e;
        int         start;
        junk  = op ^ 4'b0101;
        start = q.size();
        for (int i = 0; i < fs; i++) begin
            e = '0; e.mr = 1'b1; e.b = 2'b01; e.alu_op = 3'b010;
            add_step(1'b0, ~z, junk, e, "fetch_wait");
        end
        e = '0; e.mr = 1'b1; e.b = 2'b01; e.alu_op = 3'b010; e.irw = 1'b1; e.pcw = 1'b1;
        add_step(1'b1, ~z, junk, e, "fetch");
        e = '0; e.b = 2'b10; e.alu_op = 3'b010;
        add_step(1'b0, ~z, op, e, "decode");
        if (op <= 4'd6) begin
            e = '0; e.a = 1'b1; e.alu_op = op[2:0];
            add_step(1'b0, ~z, junk, e, "exec_r");
            e = '0; e.rw = 1'b1;
            add_step(1'b0, ~z, junk, e, "wb_r");
        end else if (op == 4'd7) begin
            e = '0; e.a = 1'b1; e.b = 2'b10; e.alu_op = 3'b010;
            add_step(1'b0, ~z, junk, e, "exec_i");
            e = '0; e.rw = 1'b1; e.rdi = 1'b1;
            add_step(1'b0, ~z, junk, e, "wb_i");
        end else if (op == 4'd8 || op == 4'd9) begin
            e = '0; e.a = 1'b1; e.b = 2'b10; e.alu_op = 3'b010;
            add_step(1'b0, ~z, junk, e, "mem_addr");
            e = '0; e.iord = 1'b1;
            if (op == 4'd8) e.mr = 1'b1; else e.mw = 1'b1;
            for (int i = 0; i < ms; i++) add_step(1'b0, ~z, junk, e, "mem_wait");
            add_step(1'b1, ~z, junk, e, "mem_done");
            if (op == 4'd8) begin
                e = '0; e.rw = 1'b1; e.m2r = 1'b1; e.rdi = 1'b1;
                add_step(1'b0, ~z, junk, e, "wb_mem");
            end
        end else if (op == 4'd10) begin
            e = '0; e.a = 1'b1; e.alu_op = 3'b011; e.pcs = 2'b01; e.pcw = z;
            add_step(1'b0, z, junk, e, "branch");
        end else if (op == 4'd11) begin
            e = '0; e.pcs = 2'b10; e.pcw = 1'b1;
            add_step(1'b0, ~z, junk, e, "jump");
        end else begin
            e = '0; e.hlt = 1'b1; e.ill = (op != 4'hF);
            for (int i = 0; i < hold; i++) add_step(i[0], i[1], 4'(i), e, "halt_hold");
        end
        n = q.size() - start;
    endtask

    task automatic drain_n(input int k);
        for (int i = 0; i < k && q.size() > 0; i++) begin
            cur       = q.pop_front();
            cur_tag   = tq.pop_front();
            mem_ready = cur.mr;
            zero      = cur.z;
            opcode    = cur.op;
            cur_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        cur_valid = 1'b0;
    endtask

    task automatic drain();
        drain_n(q.size());
    endtask

    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        #1;
        chk("reset_outputs_zero", 32'(act), 32'd0);
        q.delete();
        tq.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000ns");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int pulses;
        mem_ready = 1'b1;
        #3;
        chk("reset_state_outputs", 32'(act), 32'd0);
        chk("reset_halted", 32'(halted), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        build(4'b0010, 0, 0, 1'b0, 0, n);
        chk("len_add", n, 4);
        chk("model_add_aluop", 32'(q[2].exp.alu_op), 32'b010);
        chk("model_add_rw_last", 32'(q[3].exp.rw), 32'd1);
        drain();

        build(4'b1000, 2, 3, 1'b0, 0, n);
        chk("len_lw_stalled", n, 10);
        pulses = 0;
        foreach (q[i]) pulses += int'(q[i].exp.irw);
        chk("model_lw_irw_once", pulses, 1);
        chk("model_lw_m2r", 32'(q[9].exp.m2r), 32'd1);
        drain();

        build(4'b1010, 0, 0, 1'b1, 0, n);
        chk("len_beq_taken", n, 3);
        chk("model_beq_pcw", 32'(q[2].exp.pcw), 32'd1);
        drain();
        build(4'b1010, 0, 0, 1'b0, 0, n);
        chk("len_beq_not_taken", n, 3);
        drain();

        build(4'b0110, 0, 0, 1'b0, 0, n);
        chk("model_xor_aluop", 32'(q[2].exp.alu_op), 32'b110);
        drain();
        build(4'b1001, 1, 2, 1'b1, 0, n);
        chk("len_sw_stalled", n, 7);
        drain();
        build(4'b1001, 0, 0, 1'b0, 0, n);
        chk("len_sw", n, 4);
        drain();

        build(4'b0111, 0, 0, 1'b0, 0, n);
        chk("len_addi", n, 4);
        drain();
        build(4'b1011, 0, 0, 1'b1, 0, n);
        chk("len_jmp", n, 3);
        drain();
        for (int op = 0; op < 7; op++) begin
            build(4'(op), op % 2, 0, op[0], 0, n);
            drain();
        end

        build(4'b1111, 0, 0, 1'b0, 5, n);
        drain();
        chk("halt_op_halted", 32'(halted), 32'd1);
        chk("halt_op_not_illegal", 32'(illegal), 32'd0);
        reset_pulse();

        build(4'b1101, 0, 0, 1'b0, 20, n);
        chk("len_illegal", n, 22);
        drain();
        chk("illegal_halted", 32'(halted), 32'd1);
        chk("illegal_flag", 32'(illegal), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("illegal_reset_halted", 32'(halted), 32'd0);
        chk("illegal_reset_flag", 32'(illegal), 32'd0);
        q.delete();
        tq.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        build(4'b0011, 0, 0, 1'b0, 0, n);
        drain();

        build(4'b1001, 0, 4, 1'b0, 0, n);
        drain_n(4);
        chk("memwr_before_reset", 32'(mem_write), 32'd1);
        reset_pulse();
        chk("memwr_after_reset_rw", 32'(reg_write), 32'd0);
        build(4'b1011, 0, 0, 1'b0, 0, n);
        drain();
        build(4'b1000, 0, 0, 1'b1, 0, n);
        chk("len_lw", n, 5);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
